lif_neuron_core: RTL and testbench

Two-input leaky integrate-and-fire neuron. Each clock it weights two 4-bit unsigned stimulus inputs, adds them to an 8-bit membrane potential, subtracts a constant leak, and emits a one-cycle spike when the potential reaches threshold. After a spike the potential resets and a refractory window follows. It sits behind the chip's dedicated input pins as the compute core of the neuron tile, with the spike driving output bit 0.

---
 rtl/lif_neuron_core.sv | 70 +++++++
 tb/tb_lif_neuron_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_core.sv
// Two-input leaky integrate-and-fire neuron: weighted stimulus is integrated
// into an 8-bit membrane potential with constant leak, spike and refractory hold-off.
module lif_neuron_core #(
  parameter logic [3:0] W0      = 4'd2,
  parameter logic [3:0] W1      = 4'd3,
  parameter logic [7:0] THRESH  = 8'd20,
  parameter logic [7:0] LEAK    = 8'd1,
  parameter logic [3:0] REFRACT = 4'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  output logic       spike,
  output logic [7:0] potential,
  output logic       refractory
);

  logic              r_spike;
  logic [7:0]        r_potential;
  logic [3:0]        r_count;

  logic [8:0]        w_sum;
  logic signed [10:0] w_cand;
  logic [7:0]        w_clamp;
  logic              w_fire;

  // Weighted sum, leaky candidate potential, clamp and threshold test.
  // The 11-bit signed candidate spans -255..705, so neither clamp edge wraps.
  always_comb begin
    w_sum   = ({5'd0, x0} * {5'd0, W0}) + ({5'd0, x1} * {5'd0, W1});
    w_cand  = $signed({3'd0, r_potential}) + $signed({2'd0, w_sum})
            - $signed({3'd0, LEAK});
    w_clamp = 8'd0;
    if (w_cand < 11'sd0) begin
      w_clamp = 8'd0;
    end else if (w_cand > 11'sd255) begin
      w_clamp = 8'd255;
    end else begin
      w_clamp = w_cand[7:0];
    end
    w_fire = (w_clamp >= THRESH);
  end

  // Membrane state: refractory countdown overrides integration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike     <= 1'b0;
      r_potential <= 8'd0;
      r_count     <= 4'd0;
    end else if (r_count != 4'd0) begin
      r_spike     <= 1'b0;
      r_potential <= 8'd0;
      r_count     <= r_count - 4'd1;
    end else if (w_fire) begin
      r_spike     <= 1'b1;
      r_potential <= 8'd0;
      r_count     <= REFRACT;
    end else begin
      r_spike     <= 1'b0;
      r_potential <= w_clamp;
      r_count     <= 4'd0;
    end
  end

  assign spike      = r_spike;
  assign potential  = r_potential;
  assign refractory = (r_count != 4'd0);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Scoreboard bench for lif_neuron_core: three instances (default, THRESH=255,
// REFRACT=0) checked against a behavioural model plus literal expectations.
module tb_lif_neuron_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x0, x1;
  logic       spike_a, spike_b, spike_c;
  logic [7:0] pot_a, pot_b, pot_c;
  logic       refr_a, refr_b, refr_c;

  always #5 clk = ~clk;

  lif_neuron_core u_dut_a (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1),
    .spike(spike_a), .potential(pot_a), .refractory(refr_a)
  );

  lif_neuron_core #(.THRESH(8'd255)) u_dut_b (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1),
    .spike(spike_b), .potential(pot_b), .refractory(refr_b)
  );

  lif_neuron_core #(.REFRACT(4'd0)) u_dut_c (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1),
    .spike(spike_c), .potential(pot_c), .refractory(refr_c)
  );

  typedef struct {
    int sp;
    int pv;
    int rf;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int mv[3];
  int mr[3];
  int th[3] = '{20, 255, 20};
  int rp[3] = '{2, 2, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic exp_t model_step(input int k, input int a, input int b);
    exp_t e;
    int   n;
    if (mr[k] > 0) begin
      mr[k] = mr[k] - 1;
      mv[k] = 0;
      e.sp  = 0;
    end else begin
      n = mv[k] + a * 2 + b * 3 - 1;
      if (n < 0)   n = 0;
      if (n > 255) n = 255;
      if (n >= th[k]) begin
        e.sp  = 1;
        mv[k] = 0;
        mr[k] = rp[k];
      end else begin
        e.sp  = 0;
        mv[k] = n;
      end
    end
    e.pv = mv[k];
    e.rf = (mr[k] != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic compare_all(input string tag);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (q.size() == 0) begin
        check({tag, "_empty"}, 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        case (k)
          0: begin
            check({tag, "_spk_a"}, spike_a, e.sp);
            check({tag, "_pot_a"}, pot_a,   e.pv);
            check({tag, "_ref_a"}, refr_a,  e.rf);
          end
          1: begin
            check({tag, "_spk_b"}, spike_b, e.sp);
            check({tag, "_pot_b"}, pot_b,   e.pv);
            check({tag, "_ref_b"}, refr_b,  e.rf);
          end
          default: begin
            check({tag, "_spk_c"}, spike_c, e.sp);
            check({tag, "_pot_c"}, pot_c,   e.pv);
            check({tag, "_ref_c"}, refr_c,  e.rf);
          end
        endcase
      end
    end
  endtask

  // Drive one input sample, push model expectations, compare after the edge.
  task automatic step(input string tag, input int a, input int b);
    x0 = 4'(a);
    x1 = 4'(b);
    for (int k = 0; k < 3; k++) q.push_back(model_step(k, a, b));
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    exp_t z;
    z.sp = 0; z.pv = 0; z.rf = 0;
    rst = 1'b1;
    x0  = 4'd15;
    x1  = 4'd15;
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0;
      mr[k] = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < 3; k++) q.push_back(z);
      @(posedge clk);
      #1;
      compare_all("rst");
    end
    rst = 1'b0;
  endtask

  int int_pot[7] = '{6, 12, 18, 0, 0, 0, 6};
  int int_spk[7] = '{0, 0, 0, 1, 0, 0, 0};
  int int_ref[7] = '{0, 0, 0, 1, 1, 0, 0};
  int sat_pot[4] = '{74, 148, 222, 0};

  initial begin
    rst = 1'b1;
    x0  = 4'd15;
    x1  = 4'd15;
    #2;
    check("rst_async_pot", pot_a, 32'd0);
    check("rst_async_ref", refr_a, 32'd0);
    @(posedge clk);
    #1;
    do_reset(3);

    for (int i = 0; i < 7; i++) begin
      step("int", 2, 1);
      check("int_lit_pot", pot_a, int_pot[i]);
      check("int_lit_spk", spike_a, int_spk[i]);
      check("int_lit_ref", refr_a, int_ref[i]);
    end

    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step("imm", 15, 15);
      if (i < 4) check("sat_lit_pot", pot_b, sat_pot[i]);
      check("r0_lit_spk", spike_c, 32'd1);
    end
    check("imm_lit_spk_a", spike_a, 32'd0);

    do_reset(1);
    for (int i = 0; i < 3; i++) step("leak_up", 3, 0);
    check("leak_lit_15", pot_a, 32'd15);
    for (int i = 0; i < 18; i++) step("leak_dn", 0, 0);
    check("leak_lit_floor", pot_a, 32'd0);

    do_reset(1);
    step("ar_fire", 15, 15);
    step("ar_refr", 15, 15);
    check("ar_pre_ref", refr_a, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_now_ref", refr_a, 32'd0);
    check("ar_now_pot", pot_a, 32'd0);
    check("ar_now_spk", spike_a, 32'd0);
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0;
      mr[k] = 0;
    end
    #1;
    rst = 1'b0;
    step("ar_after", 2, 1);
    check("ar_lit_pot", pot_a, 32'd6);

    for (int i = 0; i < 40; i++) begin
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
